// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with optional bypass, hardwired R0
// and a one-entry-per-cycle clear sweep.
module regfile_2r1w #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] ptr;

  logic idle;
  logic r0_hit;
  logic wr_ok;
  logic wr_bad;
  logic byp_ok;

  assign idle   = (state == IDLE);
  assign r0_hit = (R0_ZERO != 0) && (wr_addr == '0);
  assign wr_ok  = wr_en && idle && !r0_hit;
  assign wr_bad = wr_en && !wr_ok;
  assign byp_ok = (BYPASS != 0) && wr_ok;

  // R0 masking wins over bypass so a hardwired zero never leaks wr_data
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (byp_ok && rd_addr_a == wr_addr)
      rd_data_a = wr_data;
    if (R0_ZERO != 0 && rd_addr_a == '0)
      rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (byp_ok && rd_addr_b == wr_addr)
      rd_data_b = wr_data;
    if (R0_ZERO != 0 && rd_addr_b == '0)
      rd_data_b = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      wr_drop  <= wr_bad;
      if (wr_ok)
        mem[wr_addr] <= wr_data;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + ADDR_W'(1);
          if (ptr == LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: two instances (bypass / R0-zero variants)
// checked by directed tables, sweep sequences and a random model run.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        clr_req = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  ra = '0;
  logic [3:0]  rb = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] rda1, rdb1, rda2, rdb2;
  logic        busy1, done1, drop1;
  logic        busy2, done2, drop2;

  int checks = 0;
  int errors = 0;

  // model: contents per instance, sweep index (-1 when idle), pulses
  logic [15:0] mm [2][16];
  int          sweep = -1;
  logic        ed [2];
  logic        edone = 1'b0;

  always #5 clk = ~clk;

  regfile_2r1w #(.BYPASS(1), .R0_ZERO(0)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(rda1), .rd_data_b(rdb1),
    .clr_req(clr_req), .clr_busy(busy1),
    .clr_done(done1), .wr_drop(drop1)
  );

  regfile_2r1w #(.BYPASS(0), .R0_ZERO(1)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(rda2), .rd_data_b(rdb2),
    .clr_req(clr_req), .clr_busy(busy2),
    .clr_done(done2), .wr_drop(drop2)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // instance 0: bypass, no R0; instance 1: no bypass, R0 zero
  function automatic logic [15:0] exp_rd(input int k, input logic [3:0] a);
    if (k == 1 && a == 4'd0)
      return 16'h0;
    if (k == 0 && wr_en && sweep < 0 && a == wr_addr)
      return wr_data;
    return mm[k][a];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++)
        mm[k][i] = '0;
      ed[k] = 1'b0;
    end
    sweep = -1;
    edone = 1'b0;
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++)
      ed[k] = wr_en && (sweep >= 0 || (k == 1 && wr_addr == 4'd0));
    edone = 1'b0;
    if (sweep < 0) begin
      for (int k = 0; k < 2; k++)
        if (wr_en && !ed[k])
          mm[k][wr_addr] = wr_data;
      if (clr_req)
        sweep = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        mm[k][sweep] = '0;
      sweep++;
      if (sweep == 16) begin
        sweep = -1;
        edone = 1'b1;
      end
    end
  endfunction

  task automatic chk_flags();
    chk("busy1", 16'(busy1), 16'(sweep >= 0));
    chk("busy2", 16'(busy2), 16'(sweep >= 0));
    chk("done1", 16'(done1), 16'(edone));
    chk("done2", 16'(done2), 16'(edone));
    chk("drop1", 16'(drop1), 16'(ed[0]));
    chk("drop2", 16'(drop2), 16'(ed[1]));
  endtask

  // one cycle: check reads, clock, advance model, check registered outputs
  task automatic tick();
    #1;
    chk("rd_a1", rda1, exp_rd(0, ra));
    chk("rd_b1", rdb1, exp_rd(0, rb));
    chk("rd_a2", rda2, exp_rd(1, ra));
    chk("rd_b2", rdb2, exp_rd(1, rb));
    @(posedge clk);
    model_edge();
    #1;
    chk_flags();
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    clr_req = 1'b0;
    reset   = 1'b0;
    model_reset();
    #1;
    chk_flags();
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a);
      rb = 4'(15 - a);
      #1;
      chk("rst_a1", rda1, 16'h0);
      chk("rst_b1", rdb1, 16'h0);
      chk("rst_a2", rda2, 16'h0);
      chk("rst_b2", rdb2, 16'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] ea1;
    logic [15:0] eb1;
    logic [15:0] ea2;
    logic [15:0] eb2;
  } vec_t;

  vec_t tv [8];
  int   n;

  initial begin
    tv[0] = '{1'b1, 4'd3,  16'hA5A5, 4'd3, 4'd15, 16'hA5A5, 16'h0,    16'h0,    16'h0};
    tv[1] = '{1'b1, 4'd15, 16'h1234, 4'd3, 4'd15, 16'hA5A5, 16'h1234, 16'hA5A5, 16'h0};
    tv[2] = '{1'b0, 4'd0,  16'h0,    4'd3, 4'd15, 16'hA5A5, 16'h1234, 16'hA5A5, 16'h1234};
    tv[3] = '{1'b1, 4'd7,  16'h0001, 4'd7, 4'd3,  16'h0001, 16'hA5A5, 16'h0,    16'hA5A5};
    tv[4] = '{1'b1, 4'd7,  16'hBEEF, 4'd7, 4'd7,  16'hBEEF, 16'hBEEF, 16'h0001, 16'h0001};
    tv[5] = '{1'b0, 4'd0,  16'h0,    4'd7, 4'd15, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
    tv[6] = '{1'b1, 4'd0,  16'h00FF, 4'd0, 4'd0,  16'h00FF, 16'h00FF, 16'h0,    16'h0};
    tv[7] = '{1'b0, 4'd0,  16'h0,    4'd0, 4'd3,  16'h00FF, 16'hA5A5, 16'h0,    16'hA5A5};

    model_reset();
    #2;
    do_reset();

    // directed write/read, bypass and R0 vectors
    for (int i = 0; i < 8; i++) begin
      wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      ra = tv[i].ra; rb = tv[i].rb;
      #1;
      chk($sformatf("tv%0d_a1", i), rda1, tv[i].ea1);
      chk($sformatf("tv%0d_b1", i), rdb1, tv[i].eb1);
      chk($sformatf("tv%0d_a2", i), rda2, tv[i].ea2);
      chk($sformatf("tv%0d_b2", i), rdb2, tv[i].eb2);
      tick();
      if (i == 6)
        chk("r0_drop2", 16'(drop2), 16'h1);
    end
    wr_en = 1'b0;

    // fill with i+1 then sweep
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      ra = 4'(n);
      rb = 4'(n - 1);
      #1;
      chk("sweep_pending", rda1, 16'(n + 1));
      if (n > 0)
        chk("sweep_cleared", rdb1, 16'h0);
      tick();
      n++;
    end
    chk("sweep_len", 16'(n), 16'd16);
    chk("sweep_done", 16'(done1), 16'h1);
    tick();
    chk("done_once", 16'(done1), 16'h0);
    for (int a = 0; a < 16; a++) begin
      ra = 4'(a);
      rb = 4'(a);
      #1;
      chk("post_clr_a", rda1, 16'h0);
      chk("post_clr_b", rdb2, 16'h0);
    end

    // write during sweep is dropped
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      wr_en = (n == 5); wr_addr = 4'd2; wr_data = 16'hFFFF;
      ra = 4'd2; rb = 4'd2;
      tick();
      if (n == 5) begin
        chk("sweep_drop1", 16'(drop1), 16'h1);
        chk("sweep_drop2", 16'(drop2), 16'h1);
      end
      n++;
    end
    wr_en = 1'b0;
    chk("sweep2_len", 16'(n), 16'd16);
    tick();
    chk("r2_stays0", rda1, 16'h0);

    // reset in the middle of a sweep
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'($urandom);
      tick();
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++)
      tick();
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done1 || done2)
        n++;
    end
    chk("no_done_after_rst", 16'(n), 16'h0);

    // randomized run against the model
    for (int i = 0; i < 500; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      ra      = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      rb      = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
